// File: rtl/rptr_empty_fwft_if.sv
// ---------------------------------------------------------------------------
// rptr_empty_fwft_if
//   Bundle of read-side FIFO signals between the read pointer / empty block
//   and its surroundings (synchronizer, memory, downstream consumer).
//
//   master : the read pointer block itself
//     in  rq2_wptr     Gray write pointer already synchronized into rclk
//     in  rdata_mem    memory read data (combinational read at raddr)
//     in  dout_ready   downstream accepts dout this cycle
//     out raddr        memory read address
//     out rptr         registered Gray read pointer
//     out rempty       registered memory-side empty
//     out rlevel       registered memory fill level seen from rclk
//     out almost_empty registered rlevel <= threshold
//     out dout         first-word-fall-through data
//     out dout_valid   dout holds a valid word
//   slave  : mirror view for the environment driving/observing the block
// ---------------------------------------------------------------------------
interface rptr_empty_fwft_if #(
  parameter int ADDRSIZE = 8,
  parameter int DSIZE    = 8
);
  logic [ADDRSIZE:0]   rq2_wptr;
  logic [DSIZE-1:0]    rdata_mem;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic [ADDRSIZE:0]   rlevel;
  logic                almost_empty;
  logic [DSIZE-1:0]    dout;
  logic                dout_valid;
  logic                dout_ready;

  modport master (
    input  rq2_wptr, rdata_mem, dout_ready,
    output raddr, rptr, rempty, rlevel, almost_empty, dout, dout_valid
  );

  modport slave (
    output rq2_wptr, rdata_mem, dout_ready,
    input  raddr, rptr, rempty, rlevel, almost_empty, dout, dout_valid
  );
endinterface

// File: rtl/rptr_empty_fwft.sv
// ---------------------------------------------------------------------------
// rptr_empty_fwft
//   Read-domain half of a dual-clock FIFO. Keeps the binary and Gray read
//   pointers, addresses the FIFO memory, and produces registered empty, fill
//   level and almost_empty from the synchronized Gray write pointer. A
//   first-word-fall-through output register with valid/ready handshake sits
//   in front of the consumer, so data appears without a read strobe.
//
//   Ports
//     rclk  : read clock
//     rrst  : asynchronous, active-high reset
//     bus   : rptr_empty_fwft_if.master (see interface header for signals)
// ---------------------------------------------------------------------------
module rptr_empty_fwft #(
  parameter int ADDRSIZE  = 8,
  parameter int DSIZE     = 8,
  parameter int AE_THRESH = 2
) (
  input  logic                 rclk,
  input  logic                 rrst,
  rptr_empty_fwft_if.master    bus
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] AE_LIMIT = PW'(AE_THRESH);

  logic [ADDRSIZE:0] rbin_q,   rbin_d;
  logic [ADDRSIZE:0] rptr_q,   rptr_d;
  logic [ADDRSIZE:0] rlevel_q, rlevel_d;
  logic              rempty_q, rempty_d;
  logic              almost_empty_q, almost_empty_d;
  logic [DSIZE-1:0]  dout_q,   dout_d;
  logic              dout_valid_q, dout_valid_d;

  logic [ADDRSIZE:0] wbin_s;
  logic              pop;

  // Gray-to-binary of the synchronized write pointer: bit i is the XOR of
  // all Gray bits from the MSB down to i.
  always_comb begin : gray_to_bin
    // NOTE: every variable written in always_comb gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    wbin_s = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      wbin_s[i] = ^(bus.rq2_wptr >> i);
    end
  end

  always_comb begin : next_state
    // Pop only when memory holds a word and the output register is free or
    // being drained this cycle; this also keeps rdata_mem unsampled while
    // it may be undefined.
    pop = ~rempty_q & (~dout_valid_q | bus.dout_ready);

    rbin_d   = rbin_q + PW'(pop);
    rptr_d   = (rbin_d >> 1) ^ rbin_d;

    // Compare against the pointer value after this edge so empty is already
    // correct for the cycle that follows.
    rempty_d = (rptr_d == bus.rq2_wptr);

    // Modulo subtraction handles pointer wrap; the word sitting in dout is
    // deliberately not counted.
    rlevel_d       = wbin_s - rbin_d;
    almost_empty_d = (rlevel_d <= AE_LIMIT);

    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (pop) begin
      // Covers both the initial fill and a consume-and-refill in one cycle.
      dout_d       = bus.rdata_mem;
      dout_valid_d = 1'b1;
    end else if (bus.dout_ready & dout_valid_q) begin
      dout_valid_d = 1'b0;
    end
  end

  // NOTE: reset is asynchronous so a mid-stream rrst drops dout_valid and
  // clears the pointers immediately, without waiting for an rclk edge.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_q         <= '0;
      rptr_q         <= '0;
      rempty_q       <= 1'b1;
      rlevel_q       <= '0;
      almost_empty_q <= 1'b1;
      dout_q         <= '0;
      dout_valid_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // computed before this edge, independent of statement order.
      rbin_q         <= rbin_d;
      rptr_q         <= rptr_d;
      rempty_q       <= rempty_d;
      rlevel_q       <= rlevel_d;
      almost_empty_q <= almost_empty_d;
      dout_q         <= dout_d;
      dout_valid_q   <= dout_valid_d;
    end
  end

  assign bus.raddr        = rbin_q[ADDRSIZE-1:0];
  assign bus.rptr         = rptr_q;
  assign bus.rempty       = rempty_q;
  assign bus.rlevel       = rlevel_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.dout         = dout_q;
  assign bus.dout_valid   = dout_valid_q;

endmodule
